// File: rtl/rle_out_arb.sv
// rle_out_arb: merges two RLE encoder channels into one shared output FIFO.
// Each channel has a one-word holding buffer. A round-robin arbiter drains the buffers.
// Latency: a word captured while the arbiter is idle and fifo_ready=1 is strobed out
// one clock later. Successive fifo_wr_req pulses are at least 3 clocks apart.
// Backpressure: fifo_ready=0 stalls the arbiter in IDLE. Full buffers drop send_readyN,
// which holds off that channel's encoder.
// Optional: define RLE_ARB_STATS_EN to add the per-channel grant counters cnt0/cnt1.
module rle_out_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_req0,
    input  logic [23:0] in_data0,
    input  logic        wr_req1,
    input  logic [23:0] in_data1,
    output logic        send_ready0,
    output logic        send_ready1,
    input  logic        fifo_ready,
    output logic        fifo_wr_req,
    output logic [24:0] fifo_data,
    output logic        err_ovf
`ifdef RLE_ARB_STATS_EN
    ,
    output logic [15:0] cnt0,
    output logic [15:0] cnt1
`endif
);

    // WRITE and HOLD give the FIFO's full flag time to react to the strobe
    // before the next grant can be made.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Holding buffers
    logic        valid0;
    logic        valid1;
    logic [23:0] data0;
    logic [23:0] data1;

    // Channel granted most recently; 1 after reset so channel 0 wins the first tie.
    logic        last_grant;

    // Arbiter decisions for the current cycle
    logic        grant;
    logic        grant_ch;
    logic        drain0;
    logic        drain1;

    // Capture / overflow qualifiers. A capture needs an empty buffer, so a
    // capture can never coincide with a drain of the same channel.
    logic        cap0;
    logic        cap1;
    logic        ovf0;
    logic        ovf1;

    assign cap0   = wr_req0 & ~valid0;
    assign cap1   = wr_req1 & ~valid1;
    assign ovf0   = wr_req0 &  valid0;
    assign ovf1   = wr_req1 &  valid1;

    assign drain0 = grant & ~grant_ch;
    assign drain1 = grant &  grant_ch;

    assign send_ready0 = ~valid0;
    assign send_ready1 = ~valid1;

    // Next-state logic and grant selection. A grant is made only from IDLE.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_ch  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fifo_ready && (valid0 || valid1)) begin
                    grant     = 1'b1;
                    state_nxt = ST_WRITE;
                    if (valid0 && valid1) begin
                        // Both channels are waiting: favour the one not served last.
                        grant_ch = ~last_grant;
                    end else begin
                        // Only one channel is waiting: serve it whatever the pointer says.
                        grant_ch = ~valid0;
                    end
                end
            end
            ST_WRITE: begin
                state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Channel 0 holding buffer: capture into an empty buffer, clear on grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid0 <= 1'b0;
            data0  <= 24'd0;
        end else begin
            if (drain0) begin
                valid0 <= 1'b0;
            end else if (cap0) begin
                valid0 <= 1'b1;
                data0  <= in_data0;
            end
        end
    end

    // Channel 1 holding buffer: capture into an empty buffer, clear on grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid1 <= 1'b0;
            data1  <= 24'd0;
        end else begin
            if (drain1) begin
                valid1 <= 1'b0;
            end else if (cap1) begin
                valid1 <= 1'b1;
                data1  <= in_data1;
            end
        end
    end

    // Registered FIFO write port. The strobe lasts one cycle, and the data
    // holds until the next grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_wr_req <= 1'b0;
            fifo_data   <= 25'd0;
        end else begin
            fifo_wr_req <= grant;
            if (grant) begin
                fifo_data <= grant_ch ? {1'b1, data1} : {1'b0, data0};
            end
        end
    end

    // Round-robin pointer follows every grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (grant) begin
            last_grant <= grant_ch;
        end
    end

    // Sticky overflow flag: set by a write to a full buffer. Only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_ovf <= 1'b0;
        end else if (ovf0 || ovf1) begin
            err_ovf <= 1'b1;
        end
    end

`ifdef RLE_ARB_STATS_EN
    // Per-channel grant counters; they wrap naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0 <= 16'd0;
            cnt1 <= 16'd0;
        end else begin
            if (drain0) begin
                cnt0 <= cnt0 + 16'd1;
            end
            if (drain1) begin
                cnt1 <= cnt1 + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/rle_out_arb.md
RLE_OUT_ARB -- requirements
Module: rle_out_arb

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Port list, clock and reset first:
  clk  input  1  global clock
  rst  input  1  asynchronous active-high reset
  wr_req0  input  1  channel-0 encoder write request, one-cycle pulse
  in_data0  input  24  channel-0 encoded word; [23] bit ID, [22:0] run length
  wr_req1  input  1  channel-1 encoder write request, one-cycle pulse
  in_data1  input  24  channel-1 encoded word, same format
  send_ready0  output  1  channel-0 holding buffer empty, encoder may write
  send_ready1  output  1  channel-1 holding buffer empty, encoder may write
  fifo_ready  input  1  shared output FIFO not full
  fifo_wr_req  output  1  shared FIFO write strobe, one-cycle pulse
  fifo_data  output  25  [24] channel ID, [23:0] encoded word
  err_ovf  output  1  sticky; set when a write request arrives at a full holding buffer

Function
REQ-003 Each channel SHALL have one 24-bit holding register plus a valid flag; send_readyN = NOT validN, combinational.
REQ-004 At a clk edge with wr_reqN=1 and validN=0, the block SHALL capture in_dataN and set validN.
REQ-005 At a clk edge with wr_reqN=1 and validN=1, the block SHALL discard the word, leave the buffer unchanged and set err_ovf.
REQ-006 FSM states: IDLE, WRITE, HOLD.
REQ-007 IDLE: if fifo_ready=1 and at least one validN=1, select a channel, load fifo_data, set fifo_wr_req=1, clear the selected validN, and go to WRITE. Otherwise stay in IDLE.
REQ-008 WRITE: set fifo_wr_req=0 and go to HOLD.
REQ-009 HOLD: go to IDLE. This one-cycle gap lets the FIFO full flag update.
REQ-010 Selection SHALL be round-robin: a last-grant pointer gives priority to the channel not granted most recently. Its reset value is 1, so channel 0 wins the first tie.
REQ-011 If only one channel is valid, that channel SHALL be granted regardless of the pointer; the pointer updates to the granted channel.
REQ-012 Latency from the capture edge to fifo_wr_req high SHALL be 1 clock when the FSM is in IDLE and fifo_ready=1. Minimum spacing between fifo_wr_req pulses SHALL be 3 clocks.
REQ-013 fifo_data SHALL hold its value until the next grant.
REQ-014 fifo_ready=0 in IDLE SHALL stall the FSM. No buffer is lost; encoders stall through send_readyN=0.
REQ-015 A capture on one channel and a grant draining the other channel SHALL both take effect on the same edge.
REQ-016 A capture on a channel can never coincide with a drain of that same channel, because capture requires validN=0.
REQ-017 fifo_wr_req SHALL be registered, never combinational.

Reset
REQ-018 On rst=1, asynchronously:
  - state=IDLE
  - valid0=valid1=0, so send_ready0 = send_ready1 = 1
  - fifo_wr_req=0
  - fifo_data=0
  - err_ovf=0
  - pointer=1
REQ-019 Reset asserted mid-WRITE SHALL drop any word in flight, with no partial strobe. err_ovf is cleared only by rst.

Configuration
REQ-020 Macro RLE_ARB_STATS_EN: when defined, the block SHALL add outputs cnt0 and cnt1 (16 bits each). Each counts words granted per channel, wraps 0xFFFF->0, and resets to 0.
REQ-021 Without RLE_ARB_STATS_EN, the ports and counters SHALL be absent; all other behaviour is identical.

Verification
REQ-022 Single word: wr_req0 with in_data0=0x800005, fifo_ready=1 -> fifo_wr_req high for 1 cycle, 1 clock after the capture edge; fifo_data=0x0800005; send_ready0 returns to 1.
REQ-023 Tie: wr_req0 (0x000003) and wr_req1 (0x800007) on the same edge -> channel 0 granted first (fifo_data=0x0000003); channel 1 3 clocks later (0x1800007).
REQ-024 Fairness: both channels rewrite every time send_ready rises, over 10 grants -> strictly alternating channel IDs.
REQ-025 Backpressure: fifo_ready=0 for 20 cycles with both buffers valid -> no fifo_wr_req; send_ready0 = send_ready1 = 0. fifo_ready=1 -> both words delivered, none lost.
REQ-026 Overflow: second wr_req1 while valid1=1 -> err_ovf=1; the first word is delivered unchanged.
REQ-027 Reset mid-operation: rst pulsed while in WRITE -> all outputs at reset values immediately, without waiting for a clock edge. With RLE_ARB_STATS_EN, cnt0 = cnt1 = 0.
